// File: rtl/comp3_m2_if.sv
// Status/debug plane of comp3_m2: sample enable in, registered flags and
// per-result event counters out.
interface comp3_m2_if #(
    parameter int unsigned CNT_W = 16
);
    logic             cmp_en;
    logic             gt_q;
    logic             eq_q;
    logic             lt_q;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] lt_cnt;

    // master: the controller/observer that drives the enable
    modport master (
        output cmp_en,
        input  gt_q, eq_q, lt_q,
        input  gt_cnt, eq_cnt, lt_cnt
    );

    // slave: the comparator that produces the status
    modport slave (
        input  cmp_en,
        output gt_q, eq_q, lt_q,
        output gt_cnt, eq_cnt, lt_cnt
    );
endinterface

// File: rtl/comp3_m2.sv
// Unsigned WIDTH-bit magnitude comparator (MSB-first cascade of per-bit cells)
// with one-hot combinational flags, registered flags and saturating counters.
module comp3_m2 #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    input  logic             clk,
    input  logic             rst_n,
    comp3_m2_if.slave        stat
);
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;

    assign p = a & ~b;
    assign q = a ~^ b;
    assign r = ~a & b;

    // Walk MSB to LSB; eq_run holds the AND of q over all bits above idx.
    always_comb begin
        logic eq_run;
        logic gt_acc;
        logic lt_acc;
        eq_run = 1'b1;
        gt_acc = 1'b0;
        lt_acc = 1'b0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            gt_acc = gt_acc | (p[WIDTH-1-k] & eq_run);
            lt_acc = lt_acc | (r[WIDTH-1-k] & eq_run);
            eq_run = eq_run & q[WIDTH-1-k];
        end
        gt = gt_acc;
        lt = lt_acc;
        eq = eq_run;
    end

    logic             gt_q_r;
    logic             eq_q_r;
    logic             lt_q_r;
    logic [CNT_W-1:0] gt_cnt_r;
    logic [CNT_W-1:0] eq_cnt_r;
    logic [CNT_W-1:0] lt_cnt_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_q_r   <= 1'b0;
            eq_q_r   <= 1'b0;
            lt_q_r   <= 1'b0;
            gt_cnt_r <= '0;
            eq_cnt_r <= '0;
            lt_cnt_r <= '0;
        end else if (stat.cmp_en) begin
            gt_q_r <= gt;
            eq_q_r <= eq;
            lt_q_r <= lt;
            // counters stick at all-ones instead of wrapping
            if (gt && (gt_cnt_r != '1)) gt_cnt_r <= gt_cnt_r + CNT_W'(1);
            if (eq && (eq_cnt_r != '1)) eq_cnt_r <= eq_cnt_r + CNT_W'(1);
            if (lt && (lt_cnt_r != '1)) lt_cnt_r <= lt_cnt_r + CNT_W'(1);
        end
    end

    assign stat.gt_q   = gt_q_r;
    assign stat.eq_q   = eq_q_r;
    assign stat.lt_q   = lt_q_r;
    assign stat.gt_cnt = gt_cnt_r;
    assign stat.eq_cnt = eq_cnt_r;
    assign stat.lt_cnt = lt_cnt_r;
endmodule

// File: tb/tb_comp3_m2.sv
// Directed self-checking bench for comp3_m2: one default-width-counter instance
// and one CNT_W=4 instance sharing operands, clock and reset.
module tb_comp3_m2;
    logic       clk;
    logic       rst_n;
    logic [2:0] a;
    logic [2:0] b;
    logic       gt16, eq16, lt16;
    logic       gt4, eq4, lt4;

    int n_tests = 0;
    int n_fail  = 0;

    comp3_m2_if #(.CNT_W(16)) st16 ();
    comp3_m2_if #(.CNT_W(4))  st4 ();

    comp3_m2 #(.WIDTH(3), .CNT_W(16)) dut16 (
        .a(a), .b(b), .gt(gt16), .eq(eq16), .lt(lt16),
        .clk(clk), .rst_n(rst_n), .stat(st16)
    );

    comp3_m2 #(.WIDTH(3), .CNT_W(4)) dut4 (
        .a(a), .b(b), .gt(gt4), .eq(eq4), .lt(lt4),
        .clk(clk), .rst_n(rst_n), .stat(st4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_en(input logic v);
        st16.cmp_en = v;
        st4.cmp_en  = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] ab;
    logic [8:0] bnd [6];
    logic [2:0] exp_flags;

    initial begin
        rst_n = 1'b0;
        a = '0;
        b = '0;
        set_en(1'b0);
        #3;
        check("rst_flags16", {st16.gt_q, st16.eq_q, st16.lt_q}, 3'b000);
        check("rst_cnt16", {st16.gt_cnt, st16.eq_cnt, st16.lt_cnt}, 48'h0);
        check("rst_flags4", {st4.gt_q, st4.eq_q, st4.lt_q}, 3'b000);

        for (int i = 0; i < 64; i++) begin
            ab = 6'(i);
            {a, b} = ab;
            #1;
            exp_flags = {(a > b), (a == b), (a < b)};
            check("sweep_flags", {gt16, eq16, lt16}, exp_flags);
            check("sweep_onehot", $countones({gt16, eq16, lt16}), 1);
            check("sweep_flags4", {gt4, eq4, lt4}, exp_flags);
        end

        // {a, b, expected gt/eq/lt}
        bnd[0] = {3'd7, 3'd0, 3'b100};
        bnd[1] = {3'd0, 3'd7, 3'b001};
        bnd[2] = {3'd7, 3'd7, 3'b010};
        bnd[3] = {3'd4, 3'd3, 3'b100};
        bnd[4] = {3'd3, 3'd4, 3'b001};
        bnd[5] = {3'd6, 3'd7, 3'b001};
        for (int i = 0; i < 6; i++) begin
            a = bnd[i][8:6];
            b = bnd[i][5:3];
            #1;
            check("boundary", {gt16, eq16, lt16}, bnd[i][2:0]);
        end

        // registered path: one enabled edge of a=5, b=2
        @(negedge clk);
        rst_n = 1'b1;
        a = 3'd5;
        b = 3'd2;
        set_en(1'b1);
        tick();
        set_en(1'b0);
        check("reg_flags", {st16.gt_q, st16.eq_q, st16.lt_q}, 3'b100);
        check("reg_gt_cnt", st16.gt_cnt, 1);
        check("reg_eq_cnt", st16.eq_cnt, 0);
        check("reg_lt_cnt", st16.lt_cnt, 0);
        check("reg_gt_cnt4", st4.gt_cnt, 1);

        // enable gating: 10 disabled edges with a<b
        a = 3'd1;
        b = 3'd6;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("gate_lt", lt16, 1'b1);
            check("gate_flags", {st16.gt_q, st16.eq_q, st16.lt_q}, 3'b100);
        end
        check("gate_cnts", {st16.gt_cnt, st16.eq_cnt, st16.lt_cnt}, {16'd1, 16'd0, 16'd0});

        // 20 enabled edges with a==b, then async reset between edges
        @(negedge clk);
        a = 3'd3;
        b = 3'd3;
        set_en(1'b1);
        for (int i = 0; i < 20; i++) tick();
        check("eq_run_flags", {st16.gt_q, st16.eq_q, st16.lt_q}, 3'b010);
        check("eq_run_cnt", st16.eq_cnt, 20);
        check("eq_run_cnt4_sat", st4.eq_cnt, 15);
        check("eq_run_gt_cnt", st16.gt_cnt, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_eq_q", st16.eq_q, 1'b0);
        check("async_eq_cnt", st16.eq_cnt, 0);
        check("async_gt_cnt", st16.gt_cnt, 0);
        check("async_eq_cnt4", st4.eq_cnt, 0);
        check("async_comb_eq", eq16, 1'b1);

        // saturation: a>b for 20 enabled edges
        @(negedge clk);
        rst_n = 1'b1;
        a = 3'd2;
        b = 3'd1;
        for (int i = 0; i < 20; i++) tick();
        check("sat_gt_cnt4", st4.gt_cnt, 15);
        check("sat_eq_cnt4", st4.eq_cnt, 0);
        check("sat_lt_cnt4", st4.lt_cnt, 0);
        check("sat_gt_cnt16", st16.gt_cnt, 20);

        // operands change at negedge; the following edge captures the new compare
        @(negedge clk);
        a = 3'd0;
        b = 3'd7;
        tick();
        check("late_flags", {st16.gt_q, st16.eq_q, st16.lt_q}, 3'b001);
        check("late_lt_cnt", st16.lt_cnt, 1);
        set_en(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/comp3_m2.md
# comp3_m2

Unsigned magnitude comparator for two WIDTH-bit operands, built as an MSB-first cascade of per-bit compare cells. It drives combinational one-hot greater/equal/less flags for immediate use by surrounding datapath logic. It also provides registered copies of those flags and per-result event counters for the status and debug plane.

## Interface
Parameters:
- WIDTH, 3, operand width in bits (≥1)
- CNT_W, 16, width of each result event counter

Ports (clock and reset listed first; declaration order is a, b, gt, eq, lt, clk, rst_n, then the remaining ports, so a positional a,b,gt,eq,lt hookup works):
- clk  input  1  single clock; all registered state is on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- gt  output  1  combinational, 1 iff a > b
- eq  output  1  combinational, 1 iff a == b
- lt  output  1  combinational, 1 iff a < b
- cmp_en  input  1  sample enable for the registered outputs and counters; tie to 1 when unused
- gt_q  output  1  registered gt
- eq_q  output  1  registered eq
- lt_q  output  1  registered lt
- gt_cnt  output  CNT_W  count of enabled cycles with gt=1
- eq_cnt  output  CNT_W  count of enabled cycles with eq=1
- lt_cnt  output  CNT_W  count of enabled cycles with lt=1

## Operation
- Per-bit cells for bit i:
  - p[i] = a[i] & ~b[i] (A larger at this bit)
  - q[i] = a[i] ~^ b[i] (bits equal)
  - r[i] = ~a[i] & b[i] (B larger at this bit)
- Cascade from MSB to LSB:
  - gt = OR over i of ( p[i] & AND of q[j] for all j > i ).
  - lt is the same form using r[i].
  - eq = AND of all q[i].
- gt, eq, lt are purely combinational functions of a and b and do not depend on clk, rst_n or cmp_en.
- Exactly one of gt/eq/lt is 1 for every input pair. The result is one-hot, and {gt,eq,lt} is one of 100, 010 or 001.
- Comparison is unsigned. There is no sign interpretation.
- On a rising clk edge with cmp_en=1:
  - gt_q/eq_q/lt_q load gt/eq/lt.
  - Exactly one counter, the one matching the active flag, increments by 1.
- With cmp_en=0, all registered outputs and counters hold.
- Counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- gt/eq/lt:
  - Zero-cycle latency; valid after combinational settling.
  - Must be stable within a 1 time-unit settle step after any change of a or b.
- gt_q/eq_q/lt_q and the counters:
  - One-cycle latency.
  - Update on the rising clk edge where cmp_en is sampled high.
- Reset:
  - rst_n=0 asynchronously forces gt_q=0, eq_q=0, lt_q=0 and all counters to 0, regardless of clk.
  - Registered flags read 000 until the first enabled edge after reset.
  - Reset asserted mid-run clears state immediately; the combinational outputs keep tracking a and b throughout.
- Reset release:
  - Deassertion is synchronised by the system.
  - The first edge with rst_n=1 and cmp_en=1 performs a normal update.
- a/b changing on the same edge as cmp_en:
  - The registered path captures the values settled before that edge.

## Test plan
- Exhaustive combinational sweep: drive {a,b}=i for i=0..63 (WIDTH=3) with 1 time-unit settle per value -> gt==(a>b), eq==(a==b), lt==(a<b), and exactly one flag high, for all 64 pairs.
- Boundary pairs: (7,0) -> 100; (0,7) -> 001; (7,7) -> 010; (4,3) -> 100 (MSB decides); (3,4) -> 001; (6,7) -> 001 (LSB decides).
- Registered path: reset, then cmp_en=1, a=5, b=2 for one edge -> gt_q=1, eq_q=0, lt_q=0; gt_cnt=1; eq_cnt=0; lt_cnt=0.
- Enable gating: cmp_en=0 for 10 edges with a=1, b=6 -> gt_q/eq_q/lt_q and all counters unchanged; combinational lt=1 throughout.
- Async reset mid-operation: after 20 enabled edges of eq (a=b=3), pull rst_n low between edges -> eq_q=0 and eq_cnt=0 immediately without a clock edge; eq stays 1.
- Saturation: CNT_W=4, hold a=2, b=1 with cmp_en=1 for 20 edges -> gt_cnt stops at 15; eq_cnt=0; lt_cnt=0.
